apb_regbank_slave: RTL and testbench
====================================

Name: apb_regbank_slave

Overview:
APB3/APB4 completer that sits directly downstream of the team's AXI4-Lite-to-APB bridge and services its PSEL/PENABLE transfers. It implements a small word-addressed register bank with byte-strobe writes, two read-only registers and a programmable wait-state counter. It returns PSLVERR for illegal accesses and runs on the same clock as the bridge, so the bridge's forwarded PCLK is ACLK.

Parameters:
NUM_REGS, 16, number of 32-bit word registers; legal range 3..256
BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to NUM_REGS*4
WAIT_STATES, 1, number of access-phase cycles with PREADY=0 before completion; legal range 0..15
ID_VALUE, 32'hA9B0_0001, constant returned by register 0

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  reset, asynchronous, active-high
PADDR  in  32  APB byte address
PSEL  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  1 = write, 0 = read
PWDATA  in  32  write data
PWSTRB  in  4  byte write strobes; PWSTRB[n] enables PWDATA[8n+7:8n]
PREADY  out  1  transfer complete
PRDATA  out  32  read data, valid while PREADY=1
PSLVERR  out  1  error response, valid while PREADY=1
ctrl_out  out  32  live contents of register 2, for downstream logic

Behaviour:
- Decided: reset ARESET is asynchronous and active-high; clock is ACLK. All state is cleared asynchronously while ARESET=1.
- Reset values:
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - Registers 2..NUM_REGS-1 = 0, so ctrl_out=0.
  - Cycle counter = 0.
  - FSM in IDLE.
- Register map, with idx = (PADDR-BASE_ADDR)>>2:
  - idx0: ID, read-only, returns ID_VALUE.
  - idx1: CYCLE, read-only. A 32-bit free-running counter that increments every ACLK cycle and wraps from FFFF_FFFF to 0.
  - idx2..NUM_REGS-1: read/write.
- Illegal access (sets PSLVERR=1 at completion):
  - PADDR<BASE_ADDR, or idx>=NUM_REGS.
  - PADDR[1:0]!=0.
  - Write to idx0 or idx1.
  - For an illegal access: no register changes, and PRDATA=0.
- FSM states:
  - IDLE: PREADY=0. On an edge with PSEL=1 and PENABLE=0 (setup phase), go to ACCESS and perform all of the following on that same edge:
    - Load wait_cnt=WAIT_STATES.
    - Latch the decode result (err flag, idx).
    - For a legal read, latch PRDATA_q = addressed register value; for CYCLE this is the counter value at that edge.
  - ACCESS:
    - PREADY = (wait_cnt==0), decoded from registered state with no combinational path from inputs.
    - While PREADY=0, each edge with PSEL=1 and PENABLE=1 decrements wait_cnt.
    - On an edge with PSEL=1, PENABLE=1 and PREADY=1: commit the write (legal writes only, honouring PWSTRB) and return to IDLE.
    - If PSEL=0 at any edge in ACCESS (requester abort or protocol violation): return to IDLE with no write.
- Output qualification:
  - PRDATA = PRDATA_q only when PREADY=1 and it is a legal read; otherwise 0.
  - PSLVERR = err flag only when PREADY=1; otherwise 0.
- Latency:
  - Completion occurs WAIT_STATES+1 cycles after the setup edge, i.e. the transfer spans WAIT_STATES+2 cycles in total.
  - WAIT_STATES=0 gives zero-wait APB: PREADY=1 in the first access cycle.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted normally from IDLE, so there is no idle cycle requirement beyond the APB protocol itself.
- Write commit timing: ctrl_out and readback reflect a new write from the cycle after the completion edge.
- Read-after-write to the same register returns the new value.
- Strobes:
  - PWSTRB=0000 on a legal write completes with PSLVERR=0 and changes nothing.
  - PWSTRB is ignored for reads.
- Reset asserted mid-transfer: the transfer is dropped and no partial write occurs. After release, the FSM sits in IDLE and waits for a fresh setup phase.

Test Plan:
1. Reset, then read idx0 (PADDR=BASE) with WAIT_STATES=1 -> PREADY=0 for 1 access cycle, then PREADY=1 with PRDATA=A9B0_0001 and PSLVERR=0.
2. Write 0x1234_5678 to idx2 with PWSTRB=1111, then write 0xFFFF_FFFF with PWSTRB=0101, then read idx2 -> ctrl_out=0x12FF_56FF and PRDATA=0x12FF_56FF.
3. Write to idx1 -> PSLVERR=1 and CYCLE keeps counting. Read with PADDR=BASE+NUM_REGS*4 -> PSLVERR=1, PRDATA=0. Read with PADDR=BASE+2 -> PSLVERR=1.
4. Two CYCLE reads with setup edges 10 cycles apart -> the returned values differ by exactly 10. Force the counter to FFFF_FFFF -> the next cycle reads 0.
5. Set WAIT_STATES=0 and issue back-to-back writes to idx3 and idx4 -> each completes in 2 cycles, and both values read back correctly.
6. Assert ARESET during the ACCESS phase of a write of 0xDEAD_BEEF to idx2 -> PREADY=0 immediately, and idx2 reads 0 after reset. Drop PSEL mid-wait -> FSM returns to IDLE with no write.

Source files
------------

// File: rtl/apb_regbank_slave.sv
// APB3/APB4 completer: word-addressed register bank with ID and free-running
// cycle counter, byte-strobe writes, programmable wait states and PSLVERR.
module apb_regbank_slave #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PWSTRB,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic [31:0] ctrl_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned WC_W  = 4;
  localparam int unsigned DW    = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    cycle_q, cycle_d;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic [DW-1:0]    prdata_q, prdata_d;

  logic [DW-1:0]    dec_off;
  logic [DW-3:0]    dec_word;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_err;
  logic [DW-1:0]    dec_rdata;
  logic [DW-1:0]    wmask;

  // Address decode and read mux for the current setup phase.
  always_comb begin
    dec_off  = PADDR - BASE_ADDR;
    dec_word = dec_off[DW-1:2];
    dec_idx  = dec_word[IDX_W-1:0];
    dec_err  = (PADDR < BASE_ADDR)
            || (dec_word >= (DW-2)'(NUM_REGS))
            || (dec_off[1:0] != 2'b00)
            || (PWRITE && (dec_word < (DW-2)'(2)));
    if (dec_idx == IDX_W'(0)) begin
      dec_rdata = ID_VALUE;
    end else if (dec_idx == IDX_W'(1)) begin
      dec_rdata = cycle_q;
    end else begin
      dec_rdata = regs_q[dec_idx];
    end
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{PWSTRB[b]}};
    end
  end

  // Next-state, write commit and output qualification.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    rdata_d   = rdata_q;
    regs_d    = regs_q;
    cycle_d   = cycle_q + DW'(1);
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          wait_d  = WC_W'(WAIT_STATES);
          err_d   = dec_err;
          idx_d   = dec_idx;
          rd_d    = !PWRITE && !dec_err;
          wr_d    = PWRITE && !dec_err;
          rdata_d = (!PWRITE && !dec_err) ? dec_rdata : '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (pready_q) begin
            if (wr_q) begin
              regs_d[idx_q] = (regs_q[idx_q] & ~wmask) | (PWDATA & wmask);
            end
            state_d = IDLE;
          end else begin
            wait_d = wait_q - WC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // ID and CYCLE live outside the array; keep their slots constant.
    regs_d[0] = '0;
    regs_d[1] = '0;

    pready_d  = (state_d == ACCESS) && (wait_d == '0);
    pslverr_d = pready_d && err_d;
    prdata_d  = (pready_d && rd_d) ? rdata_d : '0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      rdata_q   <= '0;
      cycle_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      cycle_q   <= cycle_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign PREADY   = pready_q;
  assign PRDATA   = prdata_q;
  assign PSLVERR  = pslverr_q;
  assign ctrl_out = regs_q[2];

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave: one instance with one wait state,
// one zero-wait instance; expectations queued at setup, compared at PREADY.
module tb_apb_regbank_slave;

  localparam int unsigned NUM_REGS = 16;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] ID       = 32'hA9B0_0001;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PWSTRB;
  logic        sel;

  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, ctrl_a, prdata_b, ctrl_b;
  logic        pready, pslverr;
  logic [31:0] prdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [2][NUM_REGS];
  logic [31:0] model_cyc;
  logic [31:0] cyc_ofs;
  int          n_checks;
  int          n_fail;
  logic [31:0] r1, r2, rd;

  always #5 ACLK = ~ACLK;

  apb_regbank_slave #(
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .WAIT_STATES(1), .ID_VALUE(ID)
  ) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .PADDR(PADDR), .PSEL(PSEL & ~sel),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PWSTRB(PWSTRB),
    .PREADY(pready_a), .PRDATA(prdata_a), .PSLVERR(pslverr_a), .ctrl_out(ctrl_a)
  );

  apb_regbank_slave #(
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(ID)
  ) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .PADDR(PADDR), .PSEL(PSEL & sel),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PWSTRB(PWSTRB),
    .PREADY(pready_b), .PRDATA(prdata_b), .PSLVERR(pslverr_b), .ctrl_out(ctrl_b)
  );

  assign pready  = sel ? pready_b  : pready_a;
  assign prdata  = sel ? prdata_b  : prdata_a;
  assign pslverr = sel ? pslverr_b : pslverr_a;

  // Reference cycle counter, cleared with the DUTs.
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) model_cyc <= '0;
    else        model_cyc <= model_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NUM_REGS; i++) mem[s][i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ACLK);
      PSEL = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  // One APB transfer; returns at the PREADY cycle, before the completion edge.
  task automatic xfer(input bit s, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata);
    logic [31:0] off;
    int          idx;
    bit          err;
    exp_t        e;
    int          lat;
    off = addr - BASE;
    idx = int'(off >> 2);
    err = (addr < BASE) || ((off >> 2) >= NUM_REGS) || (off[1:0] != 2'b00)
       || (wr && ((off >> 2) < 2));
    @(negedge ACLK);
    sel = s; PADDR = addr; PWRITE = wr; PWDATA = wdata; PWSTRB = strb;
    PSEL = 1'b1; PENABLE = 1'b0;
    e.err  = err;
    e.data = '0;
    if (!err && !wr) begin
      if (idx == 0)      e.data = ID;
      else if (idx == 1) e.data = model_cyc + cyc_ofs;
      else               e.data = mem[int'(s)][idx];
    end
    exp_q.push_back(e);
    @(negedge ACLK);
    PENABLE = 1'b1;
    lat = 0;
    while (pready !== 1'b1 && lat < 20) begin
      check($sformatf("wait_prdata@%h", addr), prdata, 32'h0);
      @(negedge ACLK);
      lat++;
    end
    check($sformatf("latency@%h", addr), 32'(lat), s ? 32'd0 : 32'd1);
    e = exp_q.pop_front();
    check($sformatf("prdata@%h", addr), prdata, e.data);
    check($sformatf("pslverr@%h", addr), 32'(pslverr), 32'(e.err));
    rdata = prdata;
    if (wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[int'(s)][idx][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc_ofs = '0;
    ARESET = 1'b1; sel = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PWDATA = '0; PWSTRB = '0;
    clear_model();
    repeat (3) @(negedge ACLK);
    check("rst_pready_a", 32'(pready_a), 32'd0);
    check("rst_prdata_a", prdata_a, 32'd0);
    check("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    check("rst_ctrl_a", ctrl_a, 32'd0);
    check("rst_pready_b", 32'(pready_b), 32'd0);
    ARESET = 1'b0;

    // ID read, strobed writes and commit timing
    xfer(0, BASE, 0, '0, 4'hF, rd);
    xfer(0, BASE + 8, 1, 32'h1234_5678, 4'b1111, rd);
    check("ctrl_before_commit", ctrl_a, 32'h0);
    xfer(0, BASE + 8, 1, 32'hFFFF_FFFF, 4'b0101, rd);
    xfer(0, BASE + 8, 0, '0, 4'b0000, rd);
    check("idx2_readback", rd, 32'h12FF_56FF);
    xfer(0, BASE + 8, 1, 32'hAAAA_AAAA, 4'b0000, rd);
    idle(1);
    check("ctrl_out", ctrl_a, 32'h12FF_56FF);

    // Illegal accesses
    xfer(0, BASE + 4, 1, 32'h5555_5555, 4'hF, rd);
    xfer(0, BASE, 1, 32'h5555_5555, 4'hF, rd);
    xfer(0, BASE + NUM_REGS * 4, 0, '0, 4'hF, rd);
    xfer(0, BASE + 2, 0, '0, 4'hF, rd);
    xfer(0, BASE - 4, 0, '0, 4'hF, rd);
    xfer(0, BASE + 9, 1, 32'h5555_5555, 4'hF, rd);
    xfer(0, BASE + 8, 0, '0, 4'hF, rd);

    // CYCLE reads with setup edges 10 cycles apart
    xfer(0, BASE + 4, 0, '0, 4'hF, r1);
    idle(7);
    xfer(0, BASE + 4, 0, '0, 4'hF, r2);
    check("cycle_delta", r2 - r1, 32'd10);

    // Zero-wait instance, back-to-back writes then readback
    xfer(1, BASE + 12, 1, 32'hCAFE_0003, 4'hF, rd);
    xfer(1, BASE + 16, 1, 32'hBEEF_0004, 4'hF, rd);
    xfer(1, BASE + 12, 0, '0, 4'hF, rd);
    xfer(1, BASE + 16, 0, '0, 4'hF, rd);
    check("b_idx4", rd, 32'hBEEF_0004);
    idle(1);
    sel = 1'b0;

    // Reset asserted in the completing access cycle of a write
    @(negedge ACLK);
    PADDR = BASE + 8; PWRITE = 1'b1; PWDATA = 32'hDEAD_BEEF; PWSTRB = 4'hF;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge ACLK);
    PENABLE = 1'b1;
    check("midrst_wait", 32'(pready_a), 32'd0);
    @(negedge ACLK);
    check("midrst_ready", 32'(pready_a), 32'd1);
    ARESET = 1'b1;
    #1;
    check("midrst_pready", 32'(pready_a), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    clear_model();
    xfer(0, BASE + 8, 0, '0, 4'hF, rd);
    check("idx2_after_rst", rd, 32'h0);
    idle(1);
    check("ctrl_after_rst", ctrl_a, 32'h0);

    // Requester drops PSEL during the wait cycle: no write
    @(negedge ACLK);
    PADDR = BASE + 20; PWRITE = 1'b1; PWDATA = 32'h55AA_55AA; PWSTRB = 4'hF;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge ACLK);
    PSEL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check($sformatf("abort_pready%0d", i), 32'(pready_a), 32'd0);
    end
    xfer(0, BASE + 20, 0, '0, 4'hF, rd);
    check("abort_nowrite", rd, 32'h0);
    idle(1);

    // Counter wrap from FFFF_FFFF
    @(negedge ACLK);
    force dut_a.cycle_q = 32'hFFFF_FFFF;
    release dut_a.cycle_q;
    cyc_ofs = 32'hFFFF_FFFF - model_cyc;
    xfer(0, BASE + 4, 0, '0, 4'hF, rd);
    check("cycle_wrap", rd, 32'h0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
